// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file for the MIPS datapath.
//   Two write ports (A, and B which is the younger instruction and wins on collision),
//   three registered read ports (A/B operands, D debug tap) with optional same-cycle
//   write forwarding, optional hardwired zero entry, and a sequential clear engine.
// Ports:
//   clock, reset                   rising-edge clock, synchronous active-high reset
//   wa_en/wa_addr/wa_data          write port A
//   wb_en/wb_addr/wb_data          write port B
//   ra_addr/rb_addr/rd_addr        read addresses (sampled each edge)
//   ra_data/rb_data/rd_data        registered read data, one edge after the address
//   clr_req                        pulse: sweep every entry to zero
//   busy                           high while the sweep runs (DEPTH cycles)
//   wr_drop                        one-cycle pulse after a write discarded during the sweep
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] rd_data,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_drop
);

  localparam int unsigned       DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_wa_ok;
  logic              w_wb_ok;
  logic [DATA_W-1:0] w_ra;
  logic [DATA_W-1:0] w_rb;
  logic [DATA_W-1:0] w_rd;

  // Read value for one port: zero entry first, then port B, then port A, then storage.
  function automatic logic [DATA_W-1:0] read_fwd(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              a_en,
    input logic [ADDR_W-1:0] a_addr,
    input logic [DATA_W-1:0] a_data,
    input logic              b_en,
    input logic [ADDR_W-1:0] b_addr,
    input logic [DATA_W-1:0] b_data
  );
    logic [DATA_W-1:0] v;
    v = stored;
    if (BYPASS != 0) begin
      if (b_en && (b_addr == addr))      v = b_data;
      else if (a_en && (a_addr == addr)) v = a_data;
    end
    if ((ZERO_REG != 0) && (addr == '0)) v = '0;
    return v;
  endfunction

  // Writes to the hardwired zero entry are swallowed without a drop pulse.
  always_comb begin
    w_wa_ok = wa_en && !((ZERO_REG != 0) && (wa_addr == '0));
    w_wb_ok = wb_en && !((ZERO_REG != 0) && (wb_addr == '0));
    w_ra    = read_fwd(ra_addr, r_mem[ra_addr], wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data);
    w_rb    = read_fwd(rb_addr, r_mem[rb_addr], wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data);
    w_rd    = read_fwd(rd_addr, r_mem[rd_addr], wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data);
  end

  // Storage, registered reads and the clear sweep.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      ra_data <= '0;
      rb_data <= '0;
      rd_data <= '0;
      busy    <= 1'b0;
      wr_drop <= 1'b0;
      r_ptr   <= '0;
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          ra_data <= w_ra;
          rb_data <= w_rb;
          rd_data <= w_rd;
          wr_drop <= 1'b0;
          // Port B assigned last so it wins an address collision.
          if (w_wa_ok) r_mem[wa_addr] <= wa_data;
          if (w_wb_ok) r_mem[wb_addr] <= wb_data;
          if (clr_req) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
            busy    <= 1'b1;
          end
        end
        S_CLEAR: begin
          ra_data       <= '0;
          rb_data       <= '0;
          rd_data       <= '0;
          wr_drop       <= wa_en | wb_en;
          r_mem[r_ptr]  <= '0;
          r_ptr         <= r_ptr + ADDR_W'(1);
          // Terminate on the last index rather than on pointer wrap.
          if (r_ptr == LAST) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: four instances (32x32 with zero reg + bypass, 32x32 plain,
// 8x16 with zero reg + bypass, 8x16 plain) share one stimulus stream and are each
// compared every cycle against a behavioural model, plus directed constant checks.
module tb_regfile_mp;

  localparam int NI = 4;
  localparam int P_AW [NI] = '{5, 5, 3, 3};
  localparam int P_Z  [NI] = '{1, 0, 1, 0};
  localparam int P_B  [NI] = '{1, 0, 1, 0};

  logic        clock = 1'b0;
  logic        reset;
  logic        wa_en, wb_en, clr_req;
  logic [4:0]  wa_addr, wb_addr, ra_addr, rb_addr, rd_addr;
  logic [31:0] wa_data, wb_data;

  logic [31:0] b0_ra, b0_rb, b0_rd, b1_ra, b1_rb, b1_rd;
  logic [15:0] s0_ra, s0_rb, s0_rd, s1_ra, s1_rb, s1_rd;
  logic        o_busy [NI];
  logic        o_drop [NI];
  logic [31:0] o_ra [NI];
  logic [31:0] o_rb [NI];
  logic [31:0] o_rd [NI];

  always #5 clock = ~clock;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_b0 (
    .clock(clock), .reset(reset),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .rd_addr(rd_addr),
    .ra_data(b0_ra), .rb_data(b0_rb), .rd_data(b0_rd),
    .clr_req(clr_req), .busy(o_busy[0]), .wr_drop(o_drop[0]));

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_b1 (
    .clock(clock), .reset(reset),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .rd_addr(rd_addr),
    .ra_data(b1_ra), .rb_data(b1_rb), .rd_data(b1_rd),
    .clr_req(clr_req), .busy(o_busy[1]), .wr_drop(o_drop[1]));

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) u_s0 (
    .clock(clock), .reset(reset),
    .wa_en(wa_en), .wa_addr(wa_addr[2:0]), .wa_data(wa_data[15:0]),
    .wb_en(wb_en), .wb_addr(wb_addr[2:0]), .wb_data(wb_data[15:0]),
    .ra_addr(ra_addr[2:0]), .rb_addr(rb_addr[2:0]), .rd_addr(rd_addr[2:0]),
    .ra_data(s0_ra), .rb_data(s0_rb), .rd_data(s0_rd),
    .clr_req(clr_req), .busy(o_busy[2]), .wr_drop(o_drop[2]));

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) u_s1 (
    .clock(clock), .reset(reset),
    .wa_en(wa_en), .wa_addr(wa_addr[2:0]), .wa_data(wa_data[15:0]),
    .wb_en(wb_en), .wb_addr(wb_addr[2:0]), .wb_data(wb_data[15:0]),
    .ra_addr(ra_addr[2:0]), .rb_addr(rb_addr[2:0]), .rd_addr(rd_addr[2:0]),
    .ra_data(s1_ra), .rb_data(s1_rb), .rd_data(s1_rd),
    .clr_req(clr_req), .busy(o_busy[3]), .wr_drop(o_drop[3]));

  assign o_ra[0] = b0_ra;           assign o_rb[0] = b0_rb;           assign o_rd[0] = b0_rd;
  assign o_ra[1] = b1_ra;           assign o_rb[1] = b1_rb;           assign o_rd[1] = b1_rd;
  assign o_ra[2] = {16'h0, s0_ra};  assign o_rb[2] = {16'h0, s0_rb};  assign o_rd[2] = {16'h0, s0_rd};
  assign o_ra[3] = {16'h0, s1_ra};  assign o_rb[3] = {16'h0, s1_rb};  assign o_rd[3] = {16'h0, s1_rd};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  // Behavioural model: array contents plus a count of sweep cycles still to run.
  logic [31:0] m_mem  [NI][32];
  int          m_left [NI];
  int          m_idx  [NI];
  logic [31:0] e_ra   [NI];
  logic [31:0] e_rb   [NI];
  logic [31:0] e_rd   [NI];
  logic        e_busy [NI];
  logic        e_drop [NI];

  function automatic logic [31:0] model_rd(input int i, input int a, input int awa, input int awb,
                                           input logic [31:0] dwa, input logic [31:0] dwb);
    if (P_Z[i] != 0 && a == 0) return 32'h0;
    if (P_B[i] != 0 && wb_en && awb == a) return dwb;
    if (P_B[i] != 0 && wa_en && awa == a) return dwa;
    return m_mem[i][a];
  endfunction

  task automatic model_step(input int i);
    int depth, awa, awb;
    logic [31:0] dmask, dwa, dwb;
    depth = 1 << P_AW[i];
    dmask = (P_AW[i] == 5) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    awa   = int'(wa_addr) % depth;
    awb   = int'(wb_addr) % depth;
    dwa   = wa_data & dmask;
    dwb   = wb_data & dmask;
    if (reset) begin
      for (int j = 0; j < 32; j++) m_mem[i][j] = 32'h0;
      e_ra[i] = 0; e_rb[i] = 0; e_rd[i] = 0;
      e_busy[i] = 1'b0; e_drop[i] = 1'b0;
      m_left[i] = 0; m_idx[i] = 0;
    end else if (m_left[i] > 0) begin
      m_mem[i][m_idx[i]] = 32'h0;
      m_idx[i]++;
      m_left[i]--;
      e_ra[i] = 0; e_rb[i] = 0; e_rd[i] = 0;
      e_drop[i] = wa_en || wb_en;
      e_busy[i] = (m_left[i] > 0);
    end else begin
      e_ra[i] = model_rd(i, int'(ra_addr) % depth, awa, awb, dwa, dwb);
      e_rb[i] = model_rd(i, int'(rb_addr) % depth, awa, awb, dwa, dwb);
      e_rd[i] = model_rd(i, int'(rd_addr) % depth, awa, awb, dwa, dwb);
      if (wa_en && !(P_Z[i] != 0 && awa == 0)) m_mem[i][awa] = dwa;
      if (wb_en && !(P_Z[i] != 0 && awb == 0)) m_mem[i][awb] = dwb;
      e_drop[i] = 1'b0;
      e_busy[i] = clr_req;
      if (clr_req) begin
        m_left[i] = depth;
        m_idx[i]  = 0;
      end
    end
  endtask

  // One clock: advance the model, take the edge, compare every instance.
  task automatic cycle();
    for (int i = 0; i < NI; i++) model_step(i);
    @(posedge clock);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("i%0d_ra", i),   o_ra[i],   e_ra[i]);
      chk($sformatf("i%0d_rb", i),   o_rb[i],   e_rb[i]);
      chk($sformatf("i%0d_rd", i),   o_rd[i],   e_rd[i]);
      chk($sformatf("i%0d_busy", i), 32'(o_busy[i]), 32'(e_busy[i]));
      chk($sformatf("i%0d_drop", i), 32'(o_drop[i]), 32'(e_drop[i]));
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; clr_req = 1'b0; wa_en = 1'b0; wb_en = 1'b0;
    wa_addr = '0; wb_addr = '0; ra_addr = '0; rb_addr = '0; rd_addr = '0;
    wa_data = '0; wb_data = '0;
  endtask

  function automatic logic [4:0] pick_addr();
    if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 3));
    return 5'($urandom);
  endfunction

  int bc;
  bit wrote;

  initial begin
    idle_inputs();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    chk("rst_busy", 32'(o_busy[0]), 32'h0);
    chk("rst_ra", o_ra[0], 32'h0);

    // Simple write then read.
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h0000_00AA;
    cycle();
    wa_en = 1'b0; ra_addr = 5'd3;
    cycle();
    chk("t1_ra", o_ra[0], 32'h0000_00AA);

    // Dual write collision: B wins; bypass instance sees it in the write cycle.
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h11;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h22;
    ra_addr = 5'd5;
    cycle();
    chk("t2_byp", o_ra[0], 32'h22);
    chk("t2_nobyp", o_ra[1], 32'h0);
    wa_en = 1'b0; wb_en = 1'b0;
    cycle();
    chk("t2_rd_b0", o_ra[0], 32'h22);
    chk("t2_rd_b1", o_ra[1], 32'h22);

    // Zero register handling.
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFF_FFFF; ra_addr = 5'd0;
    cycle();
    wa_en = 1'b0;
    cycle();
    chk("t3_zero", o_ra[0], 32'h0);
    chk("t3_zero_drop", 32'(o_drop[0]), 32'h0);
    chk("t3_plain", o_ra[1], 32'hFFFF_FFFF);

    // Fill, sweep, write during sweep.
    for (int a = 1; a < 32; a++) begin
      wa_en = 1'b1; wa_addr = 5'(a); wa_data = 32'(a);
      cycle();
    end
    wa_en = 1'b0; ra_addr = 5'd31;
    cycle();
    chk("t4_fill31", o_ra[0], 32'd31);
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    bc = o_busy[0] ? 1 : 0;
    wrote = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bc == 4 && !wrote) begin
        wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h55; wrote = 1'b1;
      end
      cycle();
      if (wa_en) begin
        chk("t4_drop", 32'(o_drop[0]), 32'h1);
        wa_en = 1'b0;
      end
      if (o_busy[0]) bc++;
    end
    chk("t4_busy_cycles", 32'(bc), 32'd32);
    for (int a = 0; a < 32; a++) begin
      ra_addr = 5'(a); rb_addr = 5'(31 - a);
      cycle();
      if (a == 7)  chk("t4_e7", o_ra[0], 32'h0);
      if (a == 31) chk("t4_e31", o_ra[0], 32'h0);
    end

    // Reset in the middle of a sweep.
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    for (int k = 1; k < 10; k++) cycle();
    chk("t5_busy_pre", 32'(o_busy[0]), 32'h1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t5_busy", 32'(o_busy[0]), 32'h0);
    chk("t5_ra", o_ra[0], 32'h0);
    wa_en = 1'b1; wa_addr = 5'd2; wa_data = 32'h9;
    cycle();
    wa_en = 1'b0; ra_addr = 5'd2;
    cycle();
    chk("t5_after", o_ra[0], 32'h9);

    // Randomised traffic with collisions, occasional sweeps and resets.
    for (int n = 0; n < 2000; n++) begin
      reset   = ($urandom_range(0, 299) == 0);
      clr_req = ($urandom_range(0, 79) == 0);
      wa_en   = 1'($urandom_range(0, 1));
      wb_en   = 1'($urandom_range(0, 1));
      wa_addr = pick_addr();
      wb_addr = pick_addr();
      ra_addr = pick_addr();
      rb_addr = pick_addr();
      rd_addr = pick_addr();
      wa_data = $urandom;
      wb_data = $urandom;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
